ram_1r1w: RTL and testbench

- Simple dual-port RAM: one synchronous write port, one synchronous read port with a registered output.
- Depth is 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Used as the per-loop stride buffer and offset buffer inside the memory walkers. It is indexed by loop id and written by both the config path and the loop-update path.

---
 rtl/ram_1r1w.sv | 52 +++++
 tb/tb_ram_1r1w.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ram_1r1w.sv
// Simple dual-port RAM with one synchronous write port and one registered synchronous read port.
// A read that collides with a write to the same address returns the old contents (read-first).
module ram_1r1w #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic                  s_write_req,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    input  logic                  s_read_req,
    output logic [DATA_WIDTH-1:0] s_read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] read_data_d;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  write_en;

    // Writes presented while reset is held are dropped; stored words survive reset.
    assign write_en = s_write_req & ~reset;

    // NOTE: the array has no reset so it can map onto block/distributed RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[s_write_addr] <= s_write_data;
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (s_read_req) begin
            read_data_d = mem_q[s_read_addr];
        end
    end

    // Read-first falls out of sampling mem_q before the same edge's write updates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign s_read_data = read_data_q;

endmodule

// File: tb/tb_ram_1r1w.sv
// Self-checking bench for ram_1r1w: a reference array produces expected read data,
// which is queued when a read is issued and compared one edge later.
module tb_ram_1r1w;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] s_write_addr = '0;
    logic          s_write_req = 1'b0;
    logic [DW-1:0] s_write_data = '0;
    logic [AW-1:0] s_read_addr = '0;
    logic          s_read_req = 1'b0;
    logic [DW-1:0] s_read_data;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            n_vectors = 0;
    int            n_miscompares = 0;

    ram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_write_addr (s_write_addr),
        .s_write_req  (s_write_req),
        .s_write_data (s_write_data),
        .s_read_addr  (s_read_addr),
        .s_read_req   (s_read_req),
        .s_read_data  (s_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // One clock edge: update the model the way the RAM should (read-first, writes masked by reset),
    // then #1 after the edge compare the queued read result.
    task automatic step(input string tag);
        bit did_read;
        did_read = (s_read_req === 1'b1) && (reset === 1'b0);
        if (did_read) exp_q.push_back(model_mem[s_read_addr]);
        if (s_write_req === 1'b1 && reset === 1'b0) model_mem[s_write_addr] = s_write_data;
        @(posedge clk);
        #1;
        if (did_read) begin
            if (exp_q.size() == 0) check({tag, "_q_empty"}, s_read_data, ~s_read_data);
            else check(tag, s_read_data, exp_q.pop_front());
        end
        s_write_req = 1'b0;
        s_read_req  = 1'b0;
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_write_addr = a;
        s_write_data = d;
        s_write_req  = 1'b1;
    endtask

    task automatic set_read(input logic [AW-1:0] a);
        s_read_addr = a;
        s_read_req  = 1'b1;
    endtask

    initial begin
        // Power-on reset: output cleared without any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("reset_por", s_read_data, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("idle");
        check("post_reset_hold", s_read_data, 16'h0000);

        // Basic write then read with one-edge latency.
        set_write(5'd3, 16'h1234);
        step("wr3");
        check("no_read_yet", s_read_data, 16'h0000);
        set_read(5'd3);
        step("basic_rd3");

        // Read hold while the word underneath changes.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_write(5'd3, 16'hBEEF);
            step("hold");
            check($sformatf("hold_%0d", i), s_read_data, 16'h1234);
        end
        set_read(5'd3);
        step("hold_reread");

        // Same-address collision is read-first.
        set_write(5'd7, 16'h0001);
        step("wr7");
        set_write(5'd7, 16'h0002);
        set_read(5'd7);
        step("collide_old");
        set_read(5'd7);
        step("collide_new");

        // Different-address read and write in the same cycle.
        set_write(5'd9, 16'h5A5A);
        set_read(5'd7);
        step("indep_rd7");
        set_read(5'd9);
        step("indep_rd9");

        // Full-range sweep, then back-to-back reads.
        for (int a = 0; a < DEPTH; a++) begin
            set_write(a[AW-1:0], 16'(a * 16'h0101));
            step("sweep_wr");
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_read(a[AW-1:0]);
            step($sformatf("sweep_rd_%0d", a));
        end

        // Reset persistence; a write during reset must not land.
        set_write(5'd0, 16'hA5A5);
        step("wr0");
        set_read(5'd31);
        step("pre_reset_rd31");
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", s_read_data, 16'h0000);
        set_write(5'd0, 16'hDEAD);
        set_read(5'd0);
        step("in_reset");
        check("reset_held", s_read_data, 16'h0000);
        reset = 1'b0;
        step("after_reset");
        check("reset_stays_zero", s_read_data, 16'h0000);
        set_read(5'd0);
        step("persist_rd0");
        check("persist_abs", s_read_data, 16'hA5A5);

        if (exp_q.size() != 0) check("q_drained", 16'(exp_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
